// File: rtl/led_seq_if.sv
// Control and pattern bus between an LED sequencer and whatever drives it.
// The master supplies run/step/mode controls; the slave (sequencer) returns the pattern and pulses.
interface led_seq_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             step;
  logic [1:0]       mode;
  logic [WIDTH-1:0] leds;
  logic             tick;
  logic             wrap;

  modport master (output en, step, mode, input leds, tick, wrap);
  modport slave  (input en, step, mode, output leds, tick, wrap);
endinterface

// File: rtl/led_seq.sv
// LED sequencer: prescaled or single-stepped advance through one of four
// patterns (binary up, binary down, bouncing one-hot, Gray count).
module led_seq #(
  parameter int WIDTH = 8,
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic     clk,
  input  logic     rst,
  led_seq_if.slave bus
);

  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {M_UP = 2'd0, M_DOWN = 2'd1, M_BOUNCE = 2'd2, M_GRAY = 2'd3} mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [DIV_W-1:0] r_pcnt;
  logic [WIDTH-1:0] r_cnt;
  logic [POS_W-1:0] r_pos;
  dir_t             r_dir;
  mode_t            r_mode_q;
  logic [WIDTH-1:0] r_leds;
  logic             r_tick;
  logic             r_wrap;

  logic             w_adv;
  logic             w_mode_chg;
  logic [DIV_W-1:0] w_pcnt_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [POS_W-1:0] w_pos_nxt;
  dir_t             w_dir_nxt;
  logic [WIDTH-1:0] w_leds_nxt;
  logic             w_wrap_nxt;

  function automatic logic [WIDTH-1:0] gray_of(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] one_hot(input logic [POS_W-1:0] p);
    return WIDTH'(1) << p;
  endfunction

  // Prescaler and next-pattern computation
  always_comb begin
    w_mode_chg = (mode_t'(bus.mode) != r_mode_q);
    w_adv      = bus.en ? (r_pcnt == DIV_W'(DIV - 1)) : bus.step;
    w_pcnt_nxt = r_pcnt;
    if (bus.en) w_pcnt_nxt = (r_pcnt == DIV_W'(DIV - 1)) ? '0 : r_pcnt + DIV_W'(1);

    w_cnt_nxt  = r_cnt;
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir;
    w_leds_nxt = r_leds;
    w_wrap_nxt = 1'b0;
    case (r_mode_q)
      M_UP: begin
        w_cnt_nxt  = r_cnt + WIDTH'(1);
        w_leds_nxt = w_cnt_nxt;
        w_wrap_nxt = &r_cnt;
      end
      M_DOWN: begin
        w_cnt_nxt  = r_cnt - WIDTH'(1);
        w_leds_nxt = w_cnt_nxt;
        w_wrap_nxt = ~|r_cnt;
      end
      M_BOUNCE: begin
        // A single LED has nowhere to bounce: every advance is a full period.
        if (WIDTH == 1) begin
          w_wrap_nxt = 1'b1;
        end else if (r_dir == DIR_UP) begin
          w_pos_nxt = r_pos + POS_W'(1);
          if (w_pos_nxt == POS_W'(WIDTH - 1)) w_dir_nxt = DIR_DOWN;
        end else begin
          w_pos_nxt = r_pos - POS_W'(1);
          if (w_pos_nxt == '0) begin
            w_dir_nxt  = DIR_UP;
            w_wrap_nxt = 1'b1;
          end
        end
        w_leds_nxt = one_hot(w_pos_nxt);
      end
      default: begin
        w_cnt_nxt  = r_cnt + WIDTH'(1);
        w_leds_nxt = gray_of(w_cnt_nxt);
        w_wrap_nxt = &r_cnt;
      end
    endcase
  end

  // State registers; a mode change restarts the pattern like a reset
  always_ff @(posedge clk) begin
    if (rst || w_mode_chg) begin
      r_pcnt   <= '0;
      r_cnt    <= '0;
      r_pos    <= '0;
      r_dir    <= DIR_UP;
      r_mode_q <= mode_t'(bus.mode);
      r_leds   <= (mode_t'(bus.mode) == M_BOUNCE) ? WIDTH'(1) : '0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_pcnt <= w_pcnt_nxt;
      r_tick <= w_adv;
      r_wrap <= w_adv & w_wrap_nxt;
      if (w_adv) begin
        r_cnt  <= w_cnt_nxt;
        r_pos  <= w_pos_nxt;
        r_dir  <= w_dir_nxt;
        r_leds <= w_leds_nxt;
      end
    end
  end

  assign bus.leds = r_leds;
  assign bus.tick = r_tick;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_led_seq.sv
// Directed bench for led_seq: four instances cover DIV=3, DIV=1, DIV=5 and a
// single-LED build; expected {leds,tick,wrap} go through a scoreboard queue.
module tb_led_seq;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [9:0] q[$];

  led_seq_if #(.WIDTH(4)) ifa ();
  led_seq_if #(.WIDTH(4)) ifb ();
  led_seq_if #(.WIDTH(4)) ifc ();
  led_seq_if #(.WIDTH(1)) ifd ();

  led_seq #(.WIDTH(4), .DIV(3), .DIV_W(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  led_seq #(.WIDTH(4), .DIV(1), .DIV_W(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  led_seq #(.WIDTH(4), .DIV(5), .DIV_W(3)) u_c (.clk(clk), .rst(rst), .bus(ifc));
  led_seq #(.WIDTH(1), .DIV(1), .DIV_W(1)) u_d (.clk(clk), .rst(rst), .bus(ifd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] obs_a();
    return {8'(ifa.leds), ifa.tick, ifa.wrap};
  endfunction
  function automatic logic [9:0] obs_b();
    return {8'(ifb.leds), ifb.tick, ifb.wrap};
  endfunction
  function automatic logic [9:0] obs_c();
    return {8'(ifc.leds), ifc.tick, ifc.wrap};
  endfunction
  function automatic logic [9:0] obs_d();
    return {8'(ifd.leds), ifd.tick, ifd.wrap};
  endfunction

  task automatic push(input logic [7:0] l, input logic t, input logic w);
    q.push_back({l, t, w});
  endtask

  task automatic chk(input string tag, input logic [9:0] obs);
    logic [9:0] e;
    e = (q.size() > 0) ? q.pop_front() : 10'bx;
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: leds/tick/wrap observed=%h/%b/%b expected=%h/%b/%b",
                tag, obs[9:2], obs[1], obs[0], e[9:2], e[1], e[0]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] bounce_seq [13];
    logic [3:0] gray_seq   [16];
    logic [3:0] n;
    logic       a;
    bounce_seq = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    gray_seq   = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                   4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    ifa.en = 1'b0; ifa.step = 1'b0; ifa.mode = 2'd0;
    ifb.en = 1'b0; ifb.step = 1'b0; ifb.mode = 2'd1;
    ifc.en = 1'b0; ifc.step = 1'b0; ifc.mode = 2'd0;
    ifd.en = 1'b0; ifd.step = 1'b0; ifd.mode = 2'd2;

    // Reset values per mode
    push(8'h0, 1'b0, 1'b0); push(8'h0, 1'b0, 1'b0);
    push(8'h0, 1'b0, 1'b0); push(8'h1, 1'b0, 1'b0);
    cyc();
    chk("rst A up", obs_a()); chk("rst B down", obs_b());
    chk("rst C up", obs_c()); chk("rst D bounce w1", obs_d());
    rst = 1'b0;

    // UP through the DIV=3 prescaler, past one wrap, ending at leds=5
    ifa.en = 1'b1;
    for (int k = 1; k <= 63; k++) begin
      a = (k % 3 == 0);
      n = 4'((k / 3) % 16);
      push(8'(n), a, a && (n == 4'h0));
      cyc();
      chk($sformatf("up div3 k=%0d", k), obs_a());
    end

    // Mode change to BOUNCE: restart without tick, then first advance 3 cycles on
    ifa.mode = 2'd2;
    push(8'h1, 1'b0, 1'b0); cyc(); chk("modechg up->bounce", obs_a());
    push(8'h1, 1'b0, 1'b0); cyc(); chk("bounce hold 1", obs_a());
    push(8'h1, 1'b0, 1'b0); cyc(); chk("bounce hold 2", obs_a());
    push(8'h2, 1'b1, 1'b0); cyc(); chk("bounce first adv", obs_a());

    // Reset mid-run loses prescaler phase
    rst = 1'b1;
    push(8'h1, 1'b0, 1'b0); cyc(); chk("midrun rst", obs_a());
    rst = 1'b0;
    push(8'h1, 1'b0, 1'b0); cyc(); chk("post-rst hold 1", obs_a());
    push(8'h1, 1'b0, 1'b0); cyc(); chk("post-rst hold 2", obs_a());
    push(8'h2, 1'b1, 1'b0); cyc(); chk("post-rst adv", obs_a());
    ifa.en = 1'b0;

    // DOWN with DIV=1: first advance wraps to all-ones
    ifb.en = 1'b1;
    push(8'hF, 1'b1, 1'b1); cyc(); chk("down 0->F", obs_b());
    push(8'hE, 1'b1, 1'b0); cyc(); chk("down F->E", obs_b());
    push(8'hD, 1'b1, 1'b0); cyc(); chk("down E->D", obs_b());
    push(8'hC, 1'b1, 1'b0); cyc(); chk("down D->C", obs_b());

    // BOUNCE from reset, wrap only on each return to 1
    ifb.mode = 2'd2;
    rst = 1'b1;
    push(8'h1, 1'b0, 1'b0); cyc(); chk("bounce rst", obs_b());
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      push(8'(bounce_seq[k]), 1'b1, bounce_seq[k] == 4'h1);
      cyc();
      chk($sformatf("bounce k=%0d", k), obs_b());
    end

    // Mode change while advancing every cycle discards that advance
    ifb.mode = 2'd3;
    push(8'h0, 1'b0, 1'b0); cyc(); chk("modechg ->gray", obs_b());
    for (int k = 0; k < 16; k++) begin
      push(8'(gray_seq[k]), 1'b1, k == 15);
      cyc();
      chk($sformatf("gray k=%0d", k), obs_b());
    end
    ifb.en = 1'b0;

    // Single-LED bounce: constant 1, wrap on every advance
    ifd.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(8'h1, 1'b1, 1'b1);
      cyc();
      chk($sformatf("width1 k=%0d", k), obs_d());
    end
    ifd.en = 1'b0;

    // Stepping while paused, then step ignored once running
    ifc.step = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      push(8'(k), 1'b1, 1'b0);
      cyc();
      chk($sformatf("step k=%0d", k), obs_c());
    end
    ifc.step = 1'b0;
    push(8'h3, 1'b0, 1'b0); cyc(); chk("paused hold 1", obs_c());
    push(8'h3, 1'b0, 1'b0); cyc(); chk("paused hold 2", obs_c());
    ifc.en   = 1'b1;
    ifc.step = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      push(8'(3 + k / 5), (k % 5 == 0), 1'b0);
      cyc();
      chk($sformatf("run div5 step-ignored k=%0d", k), obs_c());
    end
    ifc.en   = 1'b0;
    ifc.step = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_seq.md
Name: led_seq

Overview:
Parametrised LED sequencer that generalises the plain free-running LED counter. It has a built-in prescaler, four runtime-selectable patterns (binary up, binary down, bouncing single LED, Gray count), an enable, single-step control and per-advance tick and wrap pulses. It sits between the board clock and the LED pins in board tops and simulation tops, and replaces the separate clock divider plus counter pairing.

Parameters:
WIDTH, 8, number of LEDs / pattern width (>=1)
DIV, 50000000, clock cycles per pattern advance when en=1 (>=1)
DIV_W, 26, prescaler counter width; must satisfy 2^DIV_W >= DIV

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  run enable; 1 = free-run through the prescaler, 0 = paused
step  in  1  level; when en=0, each cycle with step=1 forces one advance
mode  in  2  pattern select: 0 UP, 1 DOWN, 2 BOUNCE, 3 GRAY
leds  out  WIDTH  registered pattern output
tick  out  1  registered 1-cycle pulse, coincident with every leds advance
wrap  out  1  registered 1-cycle pulse, coincident with the advance that completes a pattern cycle

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, and has priority over everything else.
- Reset at the clock edge with rst=1:
  - pcnt=0, cnt=0, pos=0, dir=up, mode_q<=mode, tick=0, wrap=0.
  - leds = 1 if mode==2, otherwise 0.
- Prescaler pcnt, range 0..DIV-1:
  - If en=1: pcnt increments each cycle; at DIV-1 it returns to 0 and adv=1 for that cycle.
  - If en=0: pcnt holds, and adv=step.
  - step is ignored while en=1.
  - DIV=1 gives adv every cycle while en=1.
- Priority each cycle: rst > mode change > adv.
- Mode change (mode != mode_q, no rst):
  - State is reinitialised exactly as in reset, using the new mode; mode_q<=mode.
  - tick=0 and wrap=0 that cycle; any coincident adv is discarded.
- Advance (adv=1, no rst, no mode change):
  - State, leds and tick update on the same edge, so leds change on the edge where the prescaler reaches DIV-1.
  - tick=1 for exactly that one cycle. wrap is per mode, below.
- Mode 0 UP: cnt <= cnt+1 mod 2^WIDTH; leds=cnt. wrap on the all-ones->0 transition.
- Mode 1 DOWN: cnt <= cnt-1 mod 2^WIDTH; leds=cnt. wrap on the 0->all-ones transition, which is the first advance after reset.
- Mode 2 BOUNCE: one-hot leds = 1<<pos.
  - dir=up: pos+1; on reaching WIDTH-1, dir flips to down.
  - dir=down: pos-1; on reaching 0, dir flips to up and wrap=1.
  - Period is 2*(WIDTH-1) advances.
  - WIDTH=1: leds stays 1 and wrap=1 on every advance.
- Mode 3 GRAY: cnt as in UP; leds = cnt ^ (cnt>>1). wrap as in UP.
- Default outputs: tick=0 and wrap=0 on every cycle without an advance.
- All arithmetic is modulo 2^WIDTH. No combinational path from inputs to outputs.
- Reset mid-run: the prescaler phase is lost, and the first advance occurs DIV cycles after rst deasserts (with en=1).

Test Plan:
1. WIDTH=4, DIV=3, mode=0, en=1 after reset -> leds 0,1,2,... changing every 3rd clk with tick each change; 16th advance gives leds=0 with wrap=1 and tick=1 in the same cycle.
2. DIV=1, mode=1, en=1 -> leds 0x0 -> 0xF (wrap=1) -> 0xE -> 0xD on consecutive cycles; wrap=0 after the first advance.
3. WIDTH=4, DIV=1, mode=2 -> leds 1,2,4,8,4,2,1,2; wrap=1 only on each return to 1 (every 6 advances); reset value leds=1.
4. WIDTH=4, DIV=1, mode=3 -> leds 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap=1 on the 8->0 advance.
5. DIV=5, en=0:
   - step held 3 cycles -> exactly 3 advances, pcnt frozen.
   - en=1 with step=1 -> step ignored; advance only every 5 cycles.
6. mode=0 running, leds=5:
   - mode->2 -> next edge leds=1, tick=0, wrap=0; BOUNCE continues from there.
   - rst=1 for 1 cycle mid-count -> leds per mode, tick=wrap=0; first advance exactly DIV cycles later.
